// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - uart_state_t : frame sequencer state encoding (3 bits)
//   - LINE_IDLE / LINE_START : serial line levels
//   - cnt_width()  : counter width helper, never narrower than 1 bit
//   - DEF_* / *_W  : default frame geometry and the counter widths it implies
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_STOP_BITS    = 1;
  localparam int DEF_CLK_CNT_W    = cnt_width(DEF_CLKS_PER_BIT);
  localparam int DEF_BIT_CNT_W    = cnt_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: data shift register and bit counter for the transmit path.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   load      in   capture data_in, clear the bit counter
//   shift     in   shift right by one, advance the bit counter
//   data_in   in   DATA_WIDTH word to serialise (LSB first)
//   lsb_next  out  bit 0 of the value the register holds after this edge
//   last_bit  out  the bit currently on the line is the final data bit
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  lsb_next,
  output logic                  last_bit
);

  localparam int BIT_W = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [BIT_W-1:0]      bit_cnt;

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = data_in;
    end else if (shift) begin
      shift_d = shift_q >> 1;
    end
  end

  // The top registers tx_out, so it needs the bit that will be on the line
  // after this edge rather than the current one.
  assign lsb_next = shift_d[0];
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      shift_q <= shift_d;
      if (load) begin
        bit_cnt <= '0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
// Sends start, DATA_WIDTH data bits (LSB first), optional parity and
// STOP_BITS stop bits, each CLKS_PER_BIT UCLK cycles long.
// Ports:
//   UCLK           in   clock
//   reset          in   asynchronous active-high reset
//   data_valid     in   upstream word present
//   parallel_data  in   word to transmit
//   parity_en      in   append parity bit to this frame (sampled at accept)
//   parity_bit     in   registered odd parity from the parity generator
//   err_inj        in   invert the parity bit of this frame (only with
//                       UART_TX_ERR_INJ_EN defined; sampled at accept)
//   par_load       out  load strobe to the parity generator (combinational)
//   tx_out         out  serial line, idles high
//   busy           out  a frame is in progress
//   tx_done        out  one-cycle pulse at frame completion
// Build option: define UART_TX_ERR_INJ_EN to add the err_inj input.
//
// state  | meaning
// IDLE   | line high; accepts a word when data_valid is high
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit from the captured generator result
// STOP   | stop bit(s) except the final cycle
//
// The final stop cycle is spent in IDLE with tx_done high. The line is high
// there anyway, and it lets a word offered in that cycle start its start bit
// on the very next cycle, so back-to-back frames have no idle gap.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  parity_en,
  input  logic                  parity_bit,
`ifdef UART_TX_ERR_INJ_EN
  input  logic                  err_inj,
`endif
  output logic                  par_load,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W       = cnt_width(CLKS_PER_BIT);
  localparam int STOP_CYCLES = STOP_BITS * CLKS_PER_BIT;
  localparam int STOP_W      = cnt_width(STOP_CYCLES);
  // STOP covers all stop cycles but the last one; exit on its final cycle.
  localparam int STOP_LAST   = (STOP_CYCLES >= 2) ? STOP_CYCLES - 2 : 0;
  // With a single stop cycle in total, that cycle is the tx_done cycle.
  localparam uart_state_t AFTER_BITS = (STOP_CYCLES == 1) ? IDLE : STOP;

  uart_state_t       state;
  uart_state_t       state_nxt;
  logic [CNT_W-1:0]  clk_cnt;
  logic [STOP_W-1:0] stop_cnt;
  logic              par_en_q;
  logic              par_q;
  logic              par_line;
  logic              bit_end;
  logic              stop_end;
  logic              shift_en;
  logic              par_cap;
  logic              done_nxt;
  logic              line_nxt;
  logic              lsb_next;
  logic              last_bit;

  assign par_load = data_valid && (state == IDLE);
  assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign stop_end = (stop_cnt == STOP_W'(STOP_LAST));

`ifdef UART_TX_ERR_INJ_EN
  logic inj_q;
  assign par_line = par_q ^ inj_q;
`else
  assign par_line = par_q;
`endif

  uart_tx_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .clk      (UCLK),
    .rst      (reset),
    .load     (par_load),
    .shift    (shift_en),
    .data_in  (parallel_data),
    .lsb_next (lsb_next),
    .last_bit (last_bit)
  );

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          // Generator was loaded at accept; its result has settled by now.
          par_cap   = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_nxt = par_en_q ? PARITY : AFTER_BITS;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = AFTER_BITS;
        end
      end
      STOP: begin
        if (stop_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    done_nxt = (state != IDLE) && (state_nxt == IDLE);
  end

  // Line level for the state being entered, so tx_out comes straight off a flop.
  always_comb begin
    line_nxt = LINE_IDLE;
    case (state_nxt)
      START:   line_nxt = LINE_START;
      DATA:    line_nxt = lsb_next;
      PARITY:  line_nxt = par_line;
      default: line_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      stop_cnt <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_out   <= LINE_IDLE;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) || bit_end) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      if (state == STOP) begin
        stop_cnt <= stop_cnt + 1'b1;
      end else begin
        stop_cnt <= '0;
      end
      if (par_load) begin
        par_en_q <= parity_en;
      end
      if (par_cap) begin
        par_q <= parity_bit;
      end
      tx_out  <= line_nxt;
      busy    <= (state_nxt != IDLE);
      tx_done <= done_nxt;
    end
  end

`ifdef UART_TX_ERR_INJ_EN
  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      inj_q <= 1'b0;
    end else if (par_load) begin
      inj_q <= err_inj;
    end
  end
`endif

endmodule
